// File: rtl/moving_average_multichannel.sv
// Multi-channel moving-average filter: one ring buffer + running sum per channel,
// runtime power-of-two window, round-half-up output with one cycle of latency.

module moving_average_channel #(
    parameter int DataWidth   = 16,
    parameter int MaxExponent = 4,
    parameter int ExpWidth    = 3,
    parameter int AccWidth    = DataWidth + MaxExponent
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clr,
    input  logic                        wr,
    input  logic [ExpWidth-1:0]         k,
    input  logic signed [DataWidth-1:0] sample,
    output logic signed [AccWidth-1:0]  acc_next,
    output logic                        primed_next
);
    localparam int Depth   = 1 << MaxExponent;
    localparam int FcWidth = MaxExponent + 1;

    logic signed [DataWidth-1:0] ring [Depth];
    logic signed [AccWidth-1:0]  acc;
    logic [MaxExponent-1:0]      wp, rp;
    logic [FcWidth-1:0]          fc, fc_inc, n;
    logic                        full;
    logic signed [DataWidth-1:0] old;

    // The ring is never cleared: fc gates which entries may leave the sum.
    always_comb begin
        n           = FcWidth'(1) << k;
        full        = (fc == n);
        rp          = wp - n[MaxExponent-1:0];
        old         = full ? ring[rp] : '0;
        acc_next    = acc - {{MaxExponent{old[DataWidth-1]}}, old}
                          + {{MaxExponent{sample[DataWidth-1]}}, sample};
        fc_inc      = fc + FcWidth'(1);
        primed_next = (fc_inc >= n);
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            acc <= '0;
            wp  <= '0;
            fc  <= '0;
        end else if (wr) begin
            acc <= acc_next;
            wp  <= wp + MaxExponent'(1);
            fc  <= full ? fc : fc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            ring[wp] <= sample;
    end
endmodule

module moving_average_multichannel #(
    parameter int DataWidth   = 16,
    parameter int MaxExponent = 4,
    parameter int Channels    = 4,
    localparam int ChanWidth  = (Channels > 1) ? $clog2(Channels) : 1,
    localparam int ExpWidth   = $clog2(MaxExponent + 1),
    localparam int AccWidth   = DataWidth + MaxExponent
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    input  logic [ChanWidth-1:0]        in_channel,
    input  logic signed [DataWidth-1:0] in_data,
    input  logic [ExpWidth-1:0]         window_exp,
    input  logic                        flush,
    output logic                        out_valid,
    output logic [ChanWidth-1:0]        out_channel,
    output logic signed [DataWidth-1:0] out_data,
    output logic                        out_primed
);
    localparam logic [ChanWidth:0] NumChan = (ChanWidth + 1)'(Channels);

    logic [ExpWidth-1:0] k_in, k_q;
    logic                flush_all, chan_ok, accept;

    logic [Channels-1:0][AccWidth-1:0] acc_next_all;
    logic [Channels-1:0]               primed_all;
    logic signed [AccWidth-1:0]        acc_sel;
    logic                              primed_sel;
    logic signed [AccWidth:0]          rnd, sum_r, avg;

    always_comb begin
        k_in      = (window_exp > ExpWidth'(MaxExponent)) ? ExpWidth'(MaxExponent) : window_exp;
        flush_all = flush || (k_in != k_q);
        chan_ok   = ({1'b0, in_channel} < NumChan);
        accept    = reset_n && in_valid && chan_ok && !flush_all;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            k_q <= k_in;
        else if (k_in != k_q)
            k_q <= k_in;
    end

    for (genvar c = 0; c < Channels; c++) begin : g_chan
        moving_average_channel #(
            .DataWidth  (DataWidth),
            .MaxExponent(MaxExponent),
            .ExpWidth   (ExpWidth),
            .AccWidth   (AccWidth)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .clr        (flush_all),
            .wr         (accept && (in_channel == ChanWidth'(c))),
            .k          (k_q),
            .sample     (in_data),
            .acc_next   (acc_next_all[c]),
            .primed_next(primed_all[c])
        );
    end

    // The sum plus the rounding term always fits; one guard bit keeps it obvious.
    always_comb begin
        acc_sel    = '0;
        primed_sel = 1'b0;
        for (int c = 0; c < Channels; c++) begin
            if (in_channel == ChanWidth'(c)) begin
                acc_sel    = acc_next_all[c];
                primed_sel = primed_all[c];
            end
        end
        rnd   = (k_q == '0) ? '0 : ((AccWidth + 1)'(1) << (k_q - ExpWidth'(1)));
        sum_r = {acc_sel[AccWidth-1], acc_sel} + rnd;
        avg   = sum_r >>> k_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_data    <= '0;
            out_primed  <= 1'b0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_channel <= in_channel;
                out_data    <= avg[DataWidth-1:0];
                out_primed  <= primed_sel;
            end
        end
    end
endmodule

// File: tb/tb_moving_average_multichannel.sv
// Bench for moving_average_multichannel: table vectors, hand sequences and random
// stimulus, with a queue-based reference model for a 4-channel and a 3-channel instance.

module tb_moving_average_multichannel;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, in_valid, flush;
    logic [1:0]  in_channel;
    logic [15:0] in_data;
    logic [2:0]  window_exp;

    logic        ov0, op0, ov1, op1;
    logic [1:0]  och0, och1;
    logic [15:0] od0, od1;

    moving_average_multichannel #(.DataWidth(16), .MaxExponent(4), .Channels(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_channel(in_channel),
        .in_data(in_data), .window_exp(window_exp), .flush(flush),
        .out_valid(ov0), .out_channel(och0), .out_data(od0), .out_primed(op0)
    );

    moving_average_multichannel #(.DataWidth(16), .MaxExponent(4), .Channels(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_channel(in_channel),
        .in_data(in_data), .window_exp(window_exp), .flush(flush),
        .out_valid(ov1), .out_channel(och1), .out_data(od1), .out_primed(op1)
    );

    int nerr = 0;
    int nchk = 0;

    // Reference model: per instance/channel, the samples seen since the last flush
    // (only the newest N are kept), averaged with floor((sum + N/2) / N).
    int mk;
    int hist [2][4][$];
    int nch  [2] = '{4, 3};
    int ev [2], ech [2], ed [2], ep [2];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int round_div(input int s, input int n);
        int t;
        t = s + n / 2;
        if (t >= 0) return t / n;
        return -((-t + n - 1) / n);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 4; c++)
                hist[i][c].delete();
    endtask

    task automatic model_edge();
        int kc, n, sum;
        kc = (window_exp > 3'd4) ? 4 : int'(window_exp);
        if (!reset_n) begin
            mk = kc;
            clear_model();
            for (int i = 0; i < 2; i++) begin
                ev[i] = 0; ech[i] = 0; ed[i] = 0; ep[i] = 0;
            end
        end else if (flush || kc != mk) begin
            mk = kc;
            clear_model();
            for (int i = 0; i < 2; i++) ev[i] = 0;
        end else begin
            n = 1 << mk;
            for (int i = 0; i < 2; i++) begin
                if (in_valid && int'(in_channel) < nch[i]) begin
                    hist[i][in_channel].push_back(int'($signed(in_data)));
                    if (hist[i][in_channel].size() > n)
                        void'(hist[i][in_channel].pop_front());
                    sum = 0;
                    foreach (hist[i][in_channel][j]) sum += hist[i][in_channel][j];
                    ev[i]  = 1;
                    ech[i] = int'(in_channel);
                    ed[i]  = round_div(sum, n);
                    ep[i]  = (hist[i][in_channel].size() == n) ? 1 : 0;
                end else begin
                    ev[i] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("valid0",  int'(ov0), ev[0]);
        chk("chan0",   int'(och0), ech[0]);
        chk("data0",   int'($signed(od0)), ed[0]);
        chk("primed0", int'(op0), ep[0]);
        chk("valid1",  int'(ov1), ev[1]);
        chk("chan1",   int'(och1), ech[1]);
        chk("data1",   int'($signed(od1)), ed[1]);
        chk("primed1", int'(op1), ep[1]);
    endtask

    task automatic cycle(input logic r, input logic v, input int ch, input int d,
                         input int we, input logic f);
        reset_n    = r;
        in_valid   = v;
        in_channel = ch[1:0];
        in_data    = d[15:0];
        window_exp = we[2:0];
        flush      = f;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    typedef struct {
        bit v; int ch; int d; int we; bit f;
        bit xv; int xch; int xd; bit xp;
    } vec_t;
    vec_t tbl[$];

    int cur_we;

    initial begin
        tbl.push_back(vec_t'{1, 0,    4, 2, 0, 1, 0,    1, 0});
        tbl.push_back(vec_t'{1, 0,    8, 2, 0, 1, 0,    3, 0});
        tbl.push_back(vec_t'{1, 0,   12, 2, 0, 1, 0,    6, 0});
        tbl.push_back(vec_t'{1, 0,   16, 2, 0, 1, 0,   10, 1});
        tbl.push_back(vec_t'{1, 0,   20, 2, 0, 1, 0,   14, 1});
        tbl.push_back(vec_t'{0, 0,    0, 1, 0, 0, 0,    0, 0});
        tbl.push_back(vec_t'{1, 2,   -3, 1, 0, 1, 2,   -1, 0});
        tbl.push_back(vec_t'{1, 2,   -4, 1, 0, 1, 2,   -3, 1});
        tbl.push_back(vec_t'{1, 0,  100, 1, 0, 1, 0,   50, 0});
        tbl.push_back(vec_t'{1, 1, -100, 1, 0, 1, 1,  -50, 0});
        tbl.push_back(vec_t'{1, 0,  100, 1, 0, 1, 0,  100, 1});
        tbl.push_back(vec_t'{1, 1, -100, 1, 0, 1, 1, -100, 1});
        tbl.push_back(vec_t'{1, 0,  100, 1, 0, 1, 0,  100, 1});
        tbl.push_back(vec_t'{1, 1, -100, 1, 0, 1, 1, -100, 1});

        cycle(0, 0, 0, 0, 2, 0);
        chk("rst_valid", int'(ov0), 0);
        chk("rst_data",  int'($signed(od0)), 0);
        cycle(0, 0, 0, 0, 2, 0);

        foreach (tbl[i]) begin
            cycle(1, tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].we, tbl[i].f);
            chk("tbl_valid", int'(ov0), int'(tbl[i].xv));
            if (tbl[i].xv) begin
                chk("tbl_chan",   int'(och0), tbl[i].xch);
                chk("tbl_data",   int'($signed(od0)), tbl[i].xd);
                chk("tbl_primed", int'(op0), int'(tbl[i].xp));
            end
        end

        // Full-scale values with the widest window, then enough zeros to wrap the ring.
        cycle(1, 0, 0, 0, 4, 0);
        for (int i = 0; i < 16; i++) cycle(1, 1, 3, 32767, 4, 0);
        chk("ext_max",        int'($signed(od0)), 32767);
        chk("ext_max_primed", int'(op0), 1);
        chk("ext_bad_ch3",    int'(ov1), 0);
        for (int i = 0; i < 16; i++) cycle(1, 1, 3, -32768, 4, 0);
        chk("ext_min", int'($signed(od0)), -32768);
        for (int i = 0; i < 20; i++) cycle(1, 1, 3, 0, 4, 0);
        chk("ext_wrap_zero", int'($signed(od0)), 0);
        chk("ext_wrap_valid", int'(ov0), 1);

        // Window change and flush both drop the coincident sample and empty the windows.
        cycle(1, 0, 0, 0, 2, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 8, 2, 0);
        chk("fill8", int'($signed(od0)), 8);
        cycle(1, 1, 0, 8, 3, 0);
        chk("wchg_drop", int'(ov0), 0);
        cycle(1, 1, 0, 8, 3, 0);
        chk("wchg_data",   int'($signed(od0)), 1);
        chk("wchg_primed", int'(op0), 0);
        cycle(1, 1, 0, 8, 3, 1);
        chk("flush_drop", int'(ov0), 0);
        cycle(1, 1, 0, 8, 3, 0);
        chk("flush_data", int'($signed(od0)), 1);

        // Mid-stream reset.
        cycle(1, 1, 1, 500, 3, 0);
        cycle(0, 1, 1, 500, 3, 0);
        chk("mrst_valid",  int'(ov0), 0);
        chk("mrst_chan",   int'(och0), 0);
        chk("mrst_data",   int'($signed(od0)), 0);
        chk("mrst_primed", int'(op0), 0);
        cycle(1, 1, 1, 40, 3, 0);
        chk("mrst_first", int'($signed(od0)), 5);

        // Out-of-range id on the 3-channel instance.
        cycle(1, 1, 3, 1000, 3, 0);
        chk("badid_valid", int'(ov1), 0);
        chk("badid_hold",  int'($signed(od1)), 5);
        cycle(1, 1, 2, 16, 3, 0);
        chk("badid_next", int'($signed(od1)), 2);

        cur_we = 3;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 2) cur_we = int'($urandom_range(0, 7));
            cycle($urandom_range(0, 149) != 0,
                  $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 65535)),
                  cur_we,
                  $urandom_range(0, 99) == 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/moving_average_multichannel.md
# moving_average_multichannel

Multi-channel, runtime-windowed moving-average filter for time-multiplexed signed sample streams. It is the parametrised successor to the single-channel fixed-window averager. It keeps an independent window per channel, takes a valid-qualified input tagged with a channel id, and rounds to nearest instead of truncating. A per-channel primed flag reports when the window is full. It sits between the feed decoder and the signal stages that consume smoothed per-instrument values.

## Interface
- DataWidth, 16, sample and output width, signed two's complement
- MaxExponent, 4, largest window exponent; buffer depth D = 2^MaxExponent
- Channels, 4, number of independent channels
- Derived (localparams): ChanWidth = max(1, clog2(Channels)); ExpWidth = clog2(MaxExponent+1); AccWidth = DataWidth + MaxExponent

Ports:
- clk  in  1  rising-edge clock; the only clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  sample present this cycle
- in_channel  in  ChanWidth  channel id of the sample; ids >= Channels are dropped
- in_data  in  DataWidth  signed sample
- window_exp  in  ExpWidth  window exponent k, window N = 2^k; values > MaxExponent clamp to MaxExponent
- flush  in  1  clears the state of all channels
- out_valid  out  1  result present this cycle
- out_channel  out  ChanWidth  channel of the result
- out_data  out  DataWidth  signed rounded average
- out_primed  out  1  channel had >= N samples since its last flush

## Operation
- Per-channel state:
  - signed accumulator acc[c] (AccWidth bits)
  - write pointer wp[c] (MaxExponent bits, wraps mod D)
  - fill count fc[c] (saturates at N)
  - D-entry sample ring buffer
- Window register k_q is loaded from clamp(window_exp) during reset.
  - Every later cycle where clamp(window_exp) != k_q: load k_q and flush all channels.
- Accepted sample (in_valid, valid id, no flush or window change that cycle), for c = in_channel:
  - old = buf[c][(wp[c] - N) mod D] when fc[c] == N, else 0. Stale or unwritten buffer contents never enter the sum, so flush never clears the buffer.
  - acc_new = acc[c] - sext(old) + sext(in_data). The result is exact and cannot overflow AccWidth.
  - buf[c][wp[c]] <= in_data; wp[c] <= wp[c]+1 mod D; fc[c] <= min(fc[c]+1, N).
  - out_data <= (acc_new + (k_q>0 ? 2^(k_q-1) : 0)) >>> k_q, truncated to DataWidth. This is round-half-up and always fits in DataWidth.
  - out_primed <= (fc[c]+1 >= N).
- Before the window is primed, out_data equals the sum so far divided by N (missing samples count as zero).
- Flush (port or window change): every channel gets acc = 0, wp = 0, fc = 0.
  - A sample arriving in the same cycle is dropped; out_valid = 0 next cycle.
- Dropped inputs (invalid channel id, flush, window change) produce no output and change no state.

## Timing
- Latency is 1 cycle. A sample accepted at edge t gives out_valid = 1 in the cycle after t, with out_channel = in_channel and an average that includes that sample.
- Throughput is one sample per cycle. Back-to-back samples to the same channel must use the updated acc, with no bubbles.
- out_valid is 0 in any cycle following a non-accepted input. out_data, out_channel and out_primed hold their last values while out_valid = 0.
- Reset values: out_valid = 0, out_channel = 0, out_data = 0, out_primed = 0; every channel's acc, wp and fc = 0.
- Reset mid-stream: the cycle after reset_n is sampled low, all outputs are at their reset values. The first sample after release starts from an empty window.
- Pointer wrap: wp wraps from D-1 to 0. The oldest-sample index uses mod-D arithmetic for every k (k = MaxExponent means old = buf[wp]).

## Test plan
- Basic average, k=2, ch0 in 4,8,12,16,20 -> out_data 1,3,6,10,14; out_primed 0,0,0,1,1.
- Negative rounding, k=1, ch2 in -3,-4 -> out_data -1,-3.
- Interleaved channels, k=1, alternate ch0=100 and ch1=-100 for 6 cycles -> ch0 outputs 50 then 100,100; ch1 outputs -50 then -100,-100; out_channel tracks input each cycle.
- Extremes and wrap, k=4:
  - 16 x 32767 on ch3 -> final out 32767, primed 1
  - then 16 x -32768 -> final out -32768
  - then 20 more x 0 -> out 0, showing wrap is correct
- Flush and window change:
  - k=2, fill ch0 with 8s, then change window_exp to 3 in the same cycle as an input -> no out_valid next cycle
  - next ch0 sample 8 -> out 1 (8 + 4 rounding term = 12, >>> 3), primed 0
  - flush asserted with in_valid -> sample dropped
- Reset and invalid id:
  - reset_n low mid-stream -> all outputs 0 next cycle
  - with Channels=3, in_channel=3 -> no out_valid and no state change
